// File: rtl/dsa_avalon_master_if.sv
// Avalon-MM bus bundle between the DSA initiator and a 32-bit slave.
// Ports (signals):
//   avm_address     master->slave  word address (ADDR_WIDTH)
//   avm_read        master->slave  read request
//   avm_write       master->slave  write request
//   avm_byteenable  master->slave  byte lanes (4'hF while a request is up)
//   avm_writedata   master->slave  write data
//   avm_readdata    slave->master  read data
//   avm_waitrequest slave->master  stall, request held while 1
`timescale 1ns/1ps
interface dsa_avalon_master_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_read;
  logic                  avm_write;
  logic [3:0]            avm_byteenable;
  logic [31:0]           avm_writedata;
  logic [31:0]           avm_readdata;
  logic                  avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/dsa_avalon_master.sv
// Avalon-MM initiator for the DSA register/memory window.
// Executes block writes (payload stream -> bus), block reads (bus -> result
// stream) and status polls (repeated read of one word until masked match or
// timeout). One bus transaction outstanding at a time.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op/addr/len/mask/value 0=WRITE 1=READ 2=POLL 3=reserved
//   wr_data/wr_valid/wr_ready  write payload stream
//   rd_data/rd_valid/rd_ready  read result stream (POLL: matching word)
//   busy, done, err            status; done pulses once per command
//   avm                        Avalon-MM master bundle
`timescale 1ns/1ps
module dsa_avalon_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int RD_LATENCY = 1,
  parameter int TMO_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [31:0]           cmd_mask,
  input  logic [31:0]           cmd_value,
  input  logic [31:0]           wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  dsa_avalon_master_if.master   avm
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_REQ    = 3'd1,
    RD_REQ    = 3'd2,
    RD_WAIT   = 3'd3,
    RD_OUT    = 3'd4,
    POLL_REQ  = 3'd5,
    POLL_WAIT = 3'd6,
    DONE      = 3'd7
  } state_t;

  // Wait counter is loaded with latency-1 so readdata is sampled exactly
  // RD_LATENCY cycles after the accepting edge.
  localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY - 1);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]  rem_r;
  logic [31:0]           mask_r;
  logic [31:0]           value_r;
  logic [2:0]            lat_r;
  logic [TMO_WIDTH-1:0]  tmo_r;
  logic                  poll_r;

  logic                  bus_accept_s;
  logic                  poll_hit_s;
  logic                  last_beat_s;
  logic                  tmo_last_s;
  logic [ADDR_WIDTH-1:0] addr_inc_s;

  assign bus_accept_s = (avm.avm_read | avm.avm_write) & ~avm.avm_waitrequest;
  assign poll_hit_s   = ((avm.avm_readdata & mask_r) == (value_r & mask_r));
  assign last_beat_s  = (rem_r == LEN_WIDTH'(1));
  // Miss on this read would bring the counter to all-ones: give up now.
  assign tmo_last_s   = (tmo_r == {{(TMO_WIDTH-1){1'b1}}, 1'b0});
  assign addr_inc_s   = addr_r + ADDR_WIDTH'(1);

  // Command FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r            <= IDLE;
      addr_r             <= {ADDR_WIDTH{1'b0}};
      rem_r              <= {LEN_WIDTH{1'b0}};
      mask_r             <= 32'h0000_0000;
      value_r            <= 32'h0000_0000;
      lat_r              <= 3'd0;
      tmo_r              <= {TMO_WIDTH{1'b0}};
      poll_r             <= 1'b0;
      cmd_ready          <= 1'b1;
      wr_ready           <= 1'b0;
      rd_data            <= 32'h0000_0000;
      rd_valid           <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      avm.avm_address    <= {ADDR_WIDTH{1'b0}};
      avm.avm_read       <= 1'b0;
      avm.avm_write      <= 1'b0;
      avm.avm_byteenable <= 4'h0;
      avm.avm_writedata  <= 32'h0000_0000;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr_r          <= cmd_addr;
            rem_r           <= cmd_len;
            mask_r          <= cmd_mask;
            value_r         <= cmd_value;
            tmo_r           <= {TMO_WIDTH{1'b0}};
            poll_r          <= (cmd_op == 2'd2);
            avm.avm_address <= cmd_addr;
            cmd_ready       <= 1'b0;
            busy            <= 1'b1;
            // Reserved op and empty block transfers finish without bus access.
            if ((cmd_op == 2'd3) || ((cmd_op != 2'd2) && (cmd_len == {LEN_WIDTH{1'b0}}))) begin
              state_r <= DONE;
              done    <= 1'b1;
              err     <= (cmd_op == 2'd3);
            end else if (cmd_op == 2'd0) begin
              state_r  <= WR_REQ;
              wr_ready <= 1'b1;
            end else begin
              state_r            <= (cmd_op == 2'd1) ? RD_REQ : POLL_REQ;
              avm.avm_read       <= 1'b1;
              avm.avm_byteenable <= 4'hF;
            end
          end
        end
        WR_REQ: begin
          if (avm.avm_write) begin
            if (bus_accept_s) begin
              avm.avm_write      <= 1'b0;
              avm.avm_byteenable <= 4'h0;
              if (last_beat_s) begin
                state_r <= DONE;
                done    <= 1'b1;
              end else begin
                addr_r          <= addr_inc_s;
                avm.avm_address <= addr_inc_s;
                rem_r           <= rem_r - LEN_WIDTH'(1);
                wr_ready        <= 1'b1;
              end
            end
          end else if (wr_valid && wr_ready) begin
            avm.avm_writedata  <= wr_data;
            avm.avm_write      <= 1'b1;
            avm.avm_byteenable <= 4'hF;
            wr_ready           <= 1'b0;
          end
        end
        RD_REQ, POLL_REQ: begin
          if (bus_accept_s) begin
            avm.avm_read       <= 1'b0;
            avm.avm_byteenable <= 4'h0;
            lat_r              <= LAT_INIT;
            state_r            <= (state_r == RD_REQ) ? RD_WAIT : POLL_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_r == 3'd0) begin
            rd_data  <= avm.avm_readdata;
            rd_valid <= 1'b1;
            state_r  <= RD_OUT;
          end else begin
            lat_r <= lat_r - 3'd1;
          end
        end
        POLL_WAIT: begin
          if (lat_r != 3'd0) begin
            lat_r <= lat_r - 3'd1;
          end else if (poll_hit_s) begin
            rd_data  <= avm.avm_readdata;
            rd_valid <= 1'b1;
            state_r  <= RD_OUT;
          end else if (tmo_last_s) begin
            state_r <= DONE;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            tmo_r              <= tmo_r + TMO_WIDTH'(1);
            avm.avm_read       <= 1'b1;
            avm.avm_byteenable <= 4'hF;
            state_r            <= POLL_REQ;
          end
        end
        RD_OUT: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (poll_r || last_beat_s) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              addr_r             <= addr_inc_s;
              avm.avm_address    <= addr_inc_s;
              rem_r              <= rem_r - LEN_WIDTH'(1);
              avm.avm_read       <= 1'b1;
              avm.avm_byteenable <= 4'hF;
              state_r            <= RD_REQ;
            end
          end
        end
        DONE: begin
          state_r   <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state_r            <= IDLE;
          cmd_ready          <= 1'b1;
          busy               <= 1'b0;
          wr_ready           <= 1'b0;
          rd_valid           <= 1'b0;
          avm.avm_read       <= 1'b0;
          avm.avm_write      <= 1'b0;
          avm.avm_byteenable <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsa_avalon_master.sv
// Directed self-checking bench for dsa_avalon_master (RD_LATENCY=1, TMO_WIDTH=4).
`timescale 1ns/1ps
module tb_dsa_avalon_master;
  localparam int AW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [31:0] cmd_mask;
  logic [31:0] cmd_value;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  dsa_avalon_master_if #(.ADDR_WIDTH(AW)) bus ();

  dsa_avalon_master #(
    .ADDR_WIDTH(16), .LEN_WIDTH(16), .RD_LATENCY(1), .TMO_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_mask(cmd_mask), .cmd_value(cmd_value),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err),
    .avm(bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model / bus monitor state
  int              done_cnt   = 0;
  int              rd_acc_cnt = 0;
  int              poll_base  = 0;
  int              match_n    = 1000;
  logic            poll_mode  = 1'b0;
  logic [AW-1:0]   last_rd_addr;
  logic [AW-1:0]   wr_addr_log[$];
  logic [31:0]     wr_data_log[$];

  // Slave: readdata valid one cycle after accept; block reads return D00D_<addr>,
  // polls return 1 from the match_n-th read onward.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (bus.avm_write && !bus.avm_waitrequest) begin
      wr_addr_log.push_back(bus.avm_address);
      wr_data_log.push_back(bus.avm_writedata);
    end
    if (bus.avm_read && !bus.avm_waitrequest) begin
      rd_acc_cnt   <= rd_acc_cnt + 1;
      last_rd_addr <= bus.avm_address;
      if (poll_mode)
        bus.avm_readdata <= ((rd_acc_cnt - poll_base + 1) >= match_n) ? 32'h1 : 32'h0;
      else
        bus.avm_readdata <= {16'hD00D, bus.avm_address};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] l,
                       input logic [31:0] m, input logic [31:0] v);
    chk("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l; cmd_mask = m; cmd_value = v;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic got_err, output logic seen_rdv,
                           output logic [31:0] rdv_data);
    logic found;
    found = 1'b0; got_err = 1'b0; seen_rdv = 1'b0; rdv_data = 32'h0;
    for (int c = 0; c < budget && !found; c++) begin
      if (rd_valid) begin seen_rdv = 1'b1; rdv_data = rd_data; end
      if (done) begin found = 1'b1; got_err = err; end
      else tick();
    end
    chk("done_within_budget", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_sig(input int budget, input bit want_read);
    for (int c = 0; c < budget; c++) begin
      if (want_read ? bus.avm_read : rd_valid) break;
      tick();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e, sv;
    logic [31:0] sd;
    logic [15:0] ea;
    int          d0, wbase, rbase, i;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 16'h0; cmd_len = 16'h0;
    cmd_mask = 32'h0; cmd_value = 32'h0; wr_data = 32'h0; wr_valid = 1'b0; rd_ready = 1'b1;
    bus.avm_waitrequest = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_flags", {24'd0, busy, done, err, wr_ready, rd_valid, bus.avm_read, bus.avm_write, 1'b0}, 32'd0);
    chk("rst_be", {28'd0, bus.avm_byteenable}, 32'd0);
    chk("rst_addr", {16'd0, bus.avm_address}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_wdata", bus.avm_writedata, 32'd0);
    reset = 1'b0;
    tick();

    // Reset held 3 cycles in the middle of a WRITE
    issue(2'd0, 16'h0020, 16'd4, 32'h0, 32'h0);
    wr_valid = 1'b1; wr_data = 32'h55;
    tick();
    wr_valid = 1'b0;
    chk("midwr_write_up", {31'd0, bus.avm_write}, 32'd1);
    d0 = done_cnt;
    reset = 1'b1;
    repeat (3) tick();
    chk("midwr_flags", {24'd0, busy, done, err, wr_ready, rd_valid, bus.avm_read, bus.avm_write, 1'b0}, 32'd0);
    chk("midwr_be_addr", {12'd0, bus.avm_byteenable, bus.avm_address}, 32'd0);
    chk("midwr_data", bus.avm_writedata | rd_data, 32'd0);
    chk("midwr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0;
    repeat (3) tick();
    chk("midwr_no_done", done_cnt, d0);

    // WRITE 0x0010 len 4, payload A0..A3
    wbase = wr_addr_log.size();
    d0 = done_cnt;
    issue(2'd0, 16'h0010, 16'd4, 32'h0, 32'h0);
    i = 0; wr_valid = 1'b1; wr_data = 32'hA0;
    for (int c = 0; c < 40 && i < 4; c++) begin
      if (wr_ready) begin
        tick(); i++; wr_data = 32'hA0 + i;
      end else begin
        tick();
      end
    end
    wr_valid = 1'b0;
    chk("wr_beats_loaded", i, 32'd4);
    wait_done(20, e, sv, sd);
    chk("wr_err", {31'd0, e}, 32'd0);
    tick();
    chk("wr_count", wr_addr_log.size() - wbase, 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (wbase + k < wr_addr_log.size()) begin
        chk("wr_addr", {16'd0, wr_addr_log[wbase+k]}, 32'h10 + k);
        chk("wr_data", wr_data_log[wbase+k], 32'hA0 + k);
      end
    end
    chk("wr_one_done", done_cnt - d0, 32'd1);
    chk("wr_idle_ready", {30'd0, cmd_ready, busy}, 32'd2);

    // READ 0xFFFE len 4 with 2 stall cycles on beat 2 (address wraps)
    issue(2'd1, 16'hFFFE, 16'd4, 32'h0, 32'h0);
    chk("rd_first_latency", {31'd0, bus.avm_read}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      ea = 16'hFFFE + 16'(b);
      wait_sig(20, 1'b1);
      chk("rd_addr", {16'd0, bus.avm_address}, {16'd0, ea});
      if (b == 1) begin
        bus.avm_waitrequest = 1'b1;
        for (int s = 0; s < 2; s++) begin
          tick();
          chk("rd_stall_read_held", {31'd0, bus.avm_read}, 32'd1);
          chk("rd_stall_addr_held", {16'd0, bus.avm_address}, {16'd0, ea});
          chk("rd_stall_be_held", {28'd0, bus.avm_byteenable}, 32'hF);
        end
        bus.avm_waitrequest = 1'b0;
      end
      tick();
      wait_sig(20, 1'b0);
      chk("rd_data", rd_data, {16'hD00D, ea});
      tick();
    end
    wait_done(20, e, sv, sd);
    chk("rd_err", {31'd0, e}, 32'd0);
    tick();

    // READ len 2 with rd_ready low for 5 cycles
    rd_ready = 1'b0;
    issue(2'd1, 16'h0100, 16'd2, 32'h0, 32'h0);
    wait_sig(20, 1'b0);
    chk("bp_data0", rd_data, 32'hD00D_0100);
    rbase = rd_acc_cnt;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid_held", {31'd0, rd_valid}, 32'd1);
      chk("bp_data_held", rd_data, 32'hD00D_0100);
      chk("bp_no_read", {31'd0, bus.avm_read}, 32'd0);
    end
    chk("bp_no_extra_reads", rd_acc_cnt - rbase, 32'd0);
    rd_ready = 1'b1;
    tick();
    wait_sig(20, 1'b1);
    chk("bp_addr1", {16'd0, bus.avm_address}, 32'h0101);
    tick();
    wait_sig(20, 1'b0);
    chk("bp_data1", rd_data, 32'hD00D_0101);
    wait_done(20, e, sv, sd);
    chk("bp_err", {31'd0, e}, 32'd0);
    tick();

    // POLL mask 1 value 1, slave returns 0,0,1
    poll_mode = 1'b1; poll_base = rd_acc_cnt; match_n = 3;
    issue(2'd2, 16'h0040, 16'hFFFF, 32'h1, 32'h1);
    wait_done(100, e, sv, sd);
    chk("poll_err", {31'd0, e}, 32'd0);
    chk("poll_rd_valid_seen", {31'd0, sv}, 32'd1);
    chk("poll_rd_data", sd, 32'h1);
    chk("poll_reads", rd_acc_cnt - poll_base, 32'd3);
    chk("poll_addr", {16'd0, last_rd_addr}, 32'h0040);
    tick();

    // POLL never matching: 2^4-1 = 15 reads, then err
    poll_base = rd_acc_cnt; match_n = 1000;
    issue(2'd2, 16'h0041, 16'd0, 32'h1, 32'h1);
    wait_done(300, e, sv, sd);
    chk("tmo_err", {31'd0, e}, 32'd1);
    chk("tmo_no_rd_valid", {31'd0, sv}, 32'd0);
    chk("tmo_reads", rd_acc_cnt - poll_base, 32'd15);
    tick();
    poll_mode = 1'b0;

    // WRITE len 0 and reserved op: done next cycle, no bus access
    rbase = rd_acc_cnt; wbase = wr_addr_log.size();
    issue(2'd0, 16'h0050, 16'd0, 32'h0, 32'h0);
    chk("len0_done", {30'd0, done, err}, 32'd2);
    chk("len0_not_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("len0_after", {30'd0, cmd_ready, done}, 32'd2);
    issue(2'd3, 16'h0060, 16'd5, 32'h0, 32'h0);
    chk("op3_done_err", {30'd0, done, err}, 32'd3);
    chk("op3_no_req", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
    tick();
    chk("op3_after", {30'd0, cmd_ready, err}, 32'd2);
    chk("nobus_reads", rd_acc_cnt - rbase, 32'd0);
    chk("nobus_writes", wr_addr_log.size() - wbase, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
